mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single backing-memory port between the instruction-fetch miss path (I) and the d_cache refill/write-through path (D).
- Arbitrates between the two requesters and sequences word-at-a-time line bursts or single-word writes.
- Returns read data to the winning requester.
- Sits between the I/D caches and main memory. The pipeline stalls (hazard path) while a requester waits on its done pulse.

Parameters:
- ADDR_W, 32, address width; word-addressed (PC steps by 1).
- DATA_W, 32, data word width.
- LINE_WORDS, 4, words per cache line; power of two, >=2.
- MAX_D_STREAK, 4, maximum consecutive D grants while I is waiting; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- i_req  in  1  I read-line request; held high until i_done.
- i_addr  in  ADDR_W  I miss address.
- i_rdata  out  DATA_W  read word to I.
- i_rvalid  out  1  i_rdata valid, one-cycle pulse per word.
- i_done  out  1  I transaction complete, one-cycle pulse.
- d_req  in  1  D request; held high until d_done.
- d_we  in  1  1 = single-word write, 0 = line read.
- d_addr  in  ADDR_W  D address.
- d_wdata  in  DATA_W  D write data.
- d_rdata  out  DATA_W  read word to D.
- d_rvalid  out  1  d_rdata valid pulse.
- d_done  out  1  D transaction complete pulse.
- mem_req  out  1  memory command valid.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  command accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.
- busy  out  1  FSM not IDLE.
- owner_d  out  1  current or last owner is D.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, beat = 0, d_streak = 0, latched owner, address and write data cleared. Reset mid-burst aborts the transaction with no done pulse. A mem_rvalid arriving in IDLE is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, grant on this edge and go to ISSUE.
  - Latch owner, we, data, and base = addr & ~(LINE_WORDS-1).
  - busy rises the cycle after the request is seen.
- Arbitration:
  - D wins when only D is requesting.
  - D also wins when both are requesting, unless d_streak == MAX_D_STREAK; then I wins.
  - I grant clears d_streak.
  - D grant with i_req high increments d_streak, saturating.
  - D grant with i_req low clears d_streak.
- ISSUE:
  - mem_req = 1, mem_addr = base + beat (wraps modulo LINE_WORDS within the line), mem_we = latched we, mem_wdata = latched data.
  - Hold until mem_ready.
  - On accept, a write goes to DONE; a read goes to WAIT.
- WAIT:
  - mem_req = 0.
  - On mem_rvalid, drive owner rdata = mem_rdata with owner rvalid = 1 for one cycle.
  - If beat == LINE_WORDS-1, go to DONE; else beat++ and return to ISSUE.
- DONE:
  - Owner done = 1 for one cycle; beat cleared; go to IDLE.
  - Requests are not sampled in DONE.
  - A requester drops req at the edge where it samples done. A req still high in IDLE starts a new transaction (legal back-to-back).
- Latency:
  - Write with a zero-wait memory: req -> done = 3 cycles.
  - Read: one ISSUE/WAIT pair per word, so with mem_ready and mem_rvalid each one cycle after the command, 2*LINE_WORDS+2 cycles.
- Only one command is outstanding at a time. No mem_rvalid is expected outside WAIT; any that arrives is ignored.
- Changes to req or addr during a transaction are ignored; latched values are used.
- owner_d is valid from ISSUE through DONE.

Optional Feature:
- Macro: MEM_ARB_CRIT_WORD_EN.
- Defined: a read burst starts at beat = addr mod LINE_WORDS (critical word first) and wraps; it completes after LINE_WORDS words. Example: LINE_WORDS = 4, addr = 0x12 issues 0x12, 0x13, 0x10, 0x11.
- Undefined: every read burst starts at beat 0 (0x10, 0x11, 0x12, 0x13).
- Writes are unaffected either way.

Test Plan:
- I read alone: i_req, i_addr = 0x12, memory returns data = addr + 0x100. Expected: mem_addr 0x10..0x13; i_rdata 0x110..0x113 with 4 i_rvalid pulses; one i_done; d_* outputs all 0.
- D write alone: d_we = 1, d_addr = 0x40, d_wdata = 0xDEADBEEF, mem_ready high. Expected: a single command with mem_we = 1, mem_addr = 0x40, mem_wdata = 0xDEADBEEF; d_done 3 cycles after d_req.
- Simultaneous i_req and d_req (read 0x80) from idle. Expected: D served first (owner_d = 1, mem_addr 0x80..0x83); I served after d_done; I receives no rvalid during the D burst.
- Starvation: d_req kept high for back-to-back writes with i_req continuously high. Expected: exactly 4 D transactions, then an I burst, then D resumes.
- Reset mid-burst: assert rst during WAIT of beat 2, then send a stray mem_rvalid after release. Expected: all outputs 0 immediately; no i_rvalid or i_done; FSM in IDLE; the next request starts at beat 0.
- With MEM_ARB_CRIT_WORD_EN defined: I read 0x13. Expected: mem_addr order 0x13, 0x10, 0x11, 0x12; without the macro the order is 0x10..0x13.

Source files
------------

// File: rtl/mem_arbiter.sv
// I/D backing-memory arbiter with bounded D streaks and line bursts.
// Optional critical-word-first reads: define MEM_ARB_CRIT_WORD_EN.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LINE_WORDS   = 4,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner_d
);

  localparam int BW = $clog2(LINE_WORDS);
  localparam logic [3:0] MAXS = 4'(MAX_D_STREAK);
  localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_t;

  state_t              state, state_nx;
  logic [BW-1:0]       beat, beat_nx;
  logic [BW-1:0]       cnt, cnt_nx;
  logic [3:0]          d_streak, d_streak_nx;
  logic                own_d, own_d_nx;
  logic                we_q, we_nx;
  logic [ADDR_W-BW-1:0] line_q, line_nx;
  logic [DATA_W-1:0]   wdata_q, wdata_nx;

  logic                grant_d;
  logic [ADDR_W-1:0]   sel_addr;
  logic [BW-1:0]       start;

  assign grant_d  = d_req && (!i_req || d_streak != MAXS);
  assign sel_addr = grant_d ? d_addr : i_addr;

  // writes always target their own word; reads pick the burst start
`ifdef MEM_ARB_CRIT_WORD_EN
  assign start = sel_addr[BW-1:0];
`else
  assign start = (grant_d && d_we) ? sel_addr[BW-1:0] : '0;
`endif

  assign busy    = (state != IDLE);
  assign owner_d = own_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      cnt      <= '0;
      d_streak <= '0;
      own_d    <= 1'b0;
      we_q     <= 1'b0;
      line_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state    <= state_nx;
      beat     <= beat_nx;
      cnt      <= cnt_nx;
      d_streak <= d_streak_nx;
      own_d    <= own_d_nx;
      we_q     <= we_nx;
      line_q   <= line_nx;
      wdata_q  <= wdata_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    beat_nx     = beat;
    cnt_nx      = cnt;
    d_streak_nx = d_streak;
    own_d_nx    = own_d;
    we_nx       = we_q;
    line_nx     = line_q;
    wdata_nx    = wdata_q;
    i_rdata     = '0;
    i_rvalid    = 1'b0;
    i_done      = 1'b0;
    d_rdata     = '0;
    d_rvalid    = 1'b0;
    d_done      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          state_nx = ISSUE;
          own_d_nx = grant_d;
          we_nx    = grant_d && d_we;
          line_nx  = sel_addr[ADDR_W-1:BW];
          wdata_nx = d_wdata;
          beat_nx  = start;
          cnt_nx   = '0;
          if (!grant_d || !i_req)
            d_streak_nx = '0;
          else if (d_streak != MAXS)
            d_streak_nx = d_streak + 4'd1;
        end
      end
      ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {line_q, beat};
        mem_wdata = wdata_q;
        if (mem_ready)
          state_nx = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (own_d) begin
            d_rdata  = mem_rdata;
            d_rvalid = 1'b1;
          end else begin
            i_rdata  = mem_rdata;
            i_rvalid = 1'b1;
          end
          if (cnt == LAST) begin
            state_nx = DONE;
          end else begin
            beat_nx  = beat + 1'b1;
            cnt_nx   = cnt + 1'b1;
            state_nx = ISSUE;
          end
        end
      end
      DONE: begin
        d_done   = own_d;
        i_done   = !own_d;
        beat_nx  = '0;
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
